// File: rtl/alu_pkg.sv
// Shared ALU definitions: multiplier sequencer states and datapath sizes.
package alu_pkg;

    localparam int MUL_WIDTH = 16;
    localparam int MUL_CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } mul_state_e;

endpackage

// File: rtl/adder.sv
// 16-bit carry-lookahead adder: four 4-bit groups with a lookahead carry chain across groups.
module adder (
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic [15:0] sum,
    output logic        carry
);

    logic [15:0] g;
    logic [15:0] p;
    logic [3:0]  grp_g;
    logic [3:0]  grp_p;
    logic [4:0]  grp_c;
    logic [15:0] c;

    // NOTE: every signal written here gets a default first, so no path can leave one unassigned and infer a latch.
    always_comb begin
        g     = a & b;
        p     = a ^ b;
        grp_g = '0;
        grp_p = '0;
        grp_c = '0;
        c     = '0;
        for (int i = 0; i < 4; i++) begin
            grp_g[i] = g[4*i+3]
                     | (p[4*i+3] & g[4*i+2])
                     | (p[4*i+3] & p[4*i+2] & g[4*i+1])
                     | (p[4*i+3] & p[4*i+2] & p[4*i+1] & g[4*i]);
            grp_p[i] = &p[4*i +: 4];
            grp_c[i+1] = grp_g[i] | (grp_p[i] & grp_c[i]);
        end
        // Group carries come from the lookahead chain; only the bits inside a group ripple.
        for (int i = 0; i < 4; i++) begin
            c[4*i] = grp_c[i];
            for (int k = 0; k < 3; k++) begin
                c[4*i+k+1] = g[4*i+k] | (p[4*i+k] & c[4*i+k]);
            end
        end
        sum   = p ^ c;
        carry = grp_c[4];
    end

endmodule

// File: rtl/shift_add_multiplier.sv
// Sequential 16x16->32 unsigned shift-and-add multiplier reusing the 16-bit adder once per step.
// Build option MUL_EARLY_TERM_EN: finish as soon as the remaining multiplier bits are all zero.
module shift_add_multiplier
    import alu_pkg::*;
#(
    parameter int WIDTH = MUL_WIDTH,
    parameter int CNT_W = MUL_CNT_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] product
);

    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

    mul_state_e       state_q, state_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] mq_q, mq_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [WIDTH-1:0] add_b;
    logic [WIDTH-1:0] add_sum;
    logic             add_carry;

    assign add_b   = mq_q[0] ? mcand_q : '0;
    assign product = {acc_q, mq_q};

    adder u_adder (
        .a     (acc_q),
        .b     (add_b),
        .sum   (add_sum),
        .carry (add_carry)
    );

    always_comb begin
        state_d   = state_q;
        mcand_d   = mcand_q;
        mq_d      = mq_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    mcand_d = a;
                    mq_d    = b;
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
`ifdef MUL_EARLY_TERM_EN
                // Unconsumed multiplier bits sit in the low WIDTH-cnt positions of mq.
                if ((mq_q & ({WIDTH{1'b1}} >> cnt_q)) == '0) begin
                    {acc_d, mq_d} = {acc_q, mq_q} >> (WIDTH - int'(cnt_q));
                    state_d       = DONE;
                end else begin
                    acc_d = {add_carry, add_sum[WIDTH-1:1]};
                    mq_d  = {add_sum[0], mq_q[WIDTH-1:1]};
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_STEP) begin
                        state_d = DONE;
                    end
                end
`else
                // The carry becomes the top bit of the shifted accumulator, so nothing is lost.
                acc_d = {add_carry, add_sum[WIDTH-1:1]};
                mq_d  = {add_sum[0], mq_q[WIDTH-1:1]};
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_STEP) begin
                    state_d = DONE;
                end
`endif
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all of them update together from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            mcand_q <= '0;
            mq_q    <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            mcand_q <= mcand_d;
            mq_q    <= mq_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Scoreboard bench for shift_add_multiplier: the driver queues expected products and latencies, the monitor checks outputs.
module tb_shift_add_multiplier;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] a = '0;
    logic [15:0] b = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] product;

    typedef struct {
        logic [31:0] prod;
        int          lat;
        int          acc_cyc;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   hs_cyc = 0;

    shift_add_multiplier dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .product   (product)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, got, want, cyc);
        end
    endtask

    function automatic int exp_lat(input logic [15:0] mb);
`ifdef MUL_EARLY_TERM_EN
        if (mb == 16'h0) return 1;
        for (int k = 15; k >= 0; k--) begin
            if (mb[k]) return (k + 2 > 16) ? 16 : k + 2;
        end
        return 1;
`else
        return (mb == 16'h0) ? 16 : 16;
`endif
    endfunction

    // Monitor: latency on the first out_valid cycle, product and in_ready on every valid cycle, pop on handshake.
    initial begin
        bit showing = 1'b0;
        forever begin
            @(negedge clk);
            #2;
            if (!rst_n) begin
                showing = 1'b0;
            end else if (out_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_output", 32'(out_valid), 32'(0));
                end else begin
                    if (!showing) begin
                        check("latency", 32'(cyc - exp_q[0].acc_cyc), 32'(exp_q[0].lat));
                    end
                    showing = 1'b1;
                    check("product", product, exp_q[0].prod);
                    check("in_ready_busy", 32'(in_ready), 32'(0));
                    if (out_ready) begin
                        void'(exp_q.pop_front());
                        hs_cyc  = cyc;
                        showing = 1'b0;
                    end
                end
            end
        end
    end

    task automatic wait_ready();
        int n = 0;
        @(negedge clk);
        while (!in_ready && n < 100) begin
            n++;
            @(negedge clk);
        end
        if (n >= 100) check("in_ready_timeout", 32'(in_ready), 32'(1));
    endtask

    task automatic issue(input logic [15:0] ia, input logic [15:0] ib,
                         input logic [31:0] ep, input bit push);
        exp_t e;
        wait_ready();
        in_valid = 1'b1;
        a        = ia;
        b        = ib;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a        = 16'hDEAD;
        b        = 16'hBEEF;
        if (push) begin
            e.prod    = ep;
            e.lat     = exp_lat(ib);
            e.acc_cyc = cyc;
            exp_q.push_back(e);
        end
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            n++;
            @(negedge clk);
        end
        if (n >= 300) check("drain_timeout", 32'(exp_q.size()), 32'(0));
    endtask

    initial begin
        int n;
        #1;
        check("reset_in_ready", 32'(in_ready), 32'(1));
        check("reset_out_valid", 32'(out_valid), 32'(0));
        check("reset_product", product, 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        issue(16'd3, 16'd5, 32'h0000_000F, 1'b1);
        issue(16'hFFFF, 16'hFFFF, 32'hFFFE_0001, 1'b1);
        issue(16'h1234, 16'h0000, 32'h0000_0000, 1'b1);
        issue(16'h1234, 16'h0001, 32'h0000_1234, 1'b1);
        drain();

        // Backpressure: hold the product for 10 cycles, then release.
        out_ready = 1'b0;
        issue(16'h8000, 16'h0002, 32'h0001_0000, 1'b1);
        n = 0;
        while (!out_valid && n < 100) begin
            n++;
            @(negedge clk);
        end
        if (n >= 100) check("bp_valid_timeout", 32'(out_valid), 32'(1));
        repeat (10) @(negedge clk);
        out_ready = 1'b1;
        @(negedge clk);
        #2;
        check("bp_back_idle_ready", 32'(in_ready), 32'(1));
        check("bp_back_idle_valid", 32'(out_valid), 32'(0));

        // Busy-ignore: operands offered mid-RUN wait until after the DONE handshake.
        issue(16'h1234, 16'h8001, 32'h091A_1234, 1'b1);
        repeat (5) @(negedge clk);
        in_valid = 1'b1;
        a        = 16'd7;
        b        = 16'd7;
        begin
            exp_t e;
            wait_ready();
            @(posedge clk);
            #1;
            in_valid  = 1'b0;
            e.prod    = 32'h0000_0031;
            e.lat     = exp_lat(16'd7);
            e.acc_cyc = cyc;
            exp_q.push_back(e);
            check("busy_accept_after_hs", 32'(cyc), 32'(hs_cyc + 2));
        end
        drain();

        // Reset in the middle of RUN: nothing emitted, clean restart.
        issue(16'hABCD, 16'hFFFF, 32'h0, 1'b0);
        repeat (8) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("midrun_rst_out_valid", 32'(out_valid), 32'(0));
        check("midrun_rst_in_ready", 32'(in_ready), 32'(1));
        check("midrun_rst_product", product, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        issue(16'h00FF, 16'h0100, 32'h0000_FF00, 1'b1);
        drain();
        repeat (20) @(negedge clk);
        check("no_spurious_valid", 32'(out_valid), 32'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
